// File: rtl/perf_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : perf_mon_pkg
// Brief    : Register map, bit indices, counter width and FSM states shared
//            by the bus performance monitor.
// Revision : 1.0
// ============================================================================
package perf_mon_pkg;

    localparam int unsigned c_cnt_width = 32;

    localparam logic [3:0] c_off_ctrl   = 4'd0;
    localparam logic [3:0] c_off_status = 4'd1;
    localparam logic [3:0] c_off_cyc_lo = 4'd2;
    localparam logic [3:0] c_off_cyc_hi = 4'd3;
    localparam logic [3:0] c_off_rd_lo  = 4'd4;
    localparam logic [3:0] c_off_rd_hi  = 4'd5;
    localparam logic [3:0] c_off_wr_lo  = 4'd6;
    localparam logic [3:0] c_off_wr_hi  = 4'd7;
    localparam logic [3:0] c_off_ins_lo = 4'd8;
    localparam logic [3:0] c_off_ins_hi = 4'd9;

    localparam int unsigned c_ctrl_clear_bit    = 0;
    localparam int unsigned c_ctrl_freeze_bit   = 1;
    localparam int unsigned c_status_frozen_bit = 0;
    localparam int unsigned c_status_ovf_bit    = 1;

    localparam int unsigned c_idx_cyc = 0;
    localparam int unsigned c_idx_rd  = 1;
    localparam int unsigned c_idx_wr  = 2;
    localparam int unsigned c_idx_ins = 3;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } mon_state_t;

    // Counter slot addressed by a lo/hi offset pair (2/3 -> 0 ... 8/9 -> 3).
    function automatic logic [1:0] cnt_index(input logic [3:0] off);
        return 2'((off - 4'd2) >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_perf_monitor_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Saturating up-counter with synchronous clear; sat flags an
//            increment request that arrives while already at full scale.
// Revision : 1.0
// ============================================================================
module sat_counter
    import perf_mon_pkg::*;
#(
    parameter int unsigned WIDTH = c_cnt_width
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             sat
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;
    logic             w_at_max;

    assign w_at_max = &r_count;
    assign sat      = en & w_at_max;
    assign count    = r_count;

    always_comb begin
        w_next = r_count;
        if (clr) begin
            w_next = '0;
        end else if (en && !w_at_max) begin
            w_next = r_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module   : bus_perf_monitor
// Brief    : Memory-mapped cycle/read/write/instruction counters with a
//            RUN/FROZEN FSM. Option macro: PERF_MON_SNAPSHOT_EN (atomic hi read).
// Revision : 1.0
// ============================================================================
module bus_perf_monitor
    import perf_mon_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH    = 20,
    parameter int unsigned           DATA_WIDTH    = 16,
    parameter logic [ADDR_WIDTH-1:0] START_ADDRESS = ADDR_WIDTH'(20'h00400)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    inout  wire  [DATA_WIDTH-1:0] bus_data,
    input  logic                  read,
    input  logic                  write,
    input  logic [9:0]            pc,
    input  logic                  halted,
    output logic                  frozen
);

    mon_state_t r_state;
    logic       r_frozen;
    logic       r_ovf;
    logic [9:0] r_prev_pc;

    logic                   w_hit;
    logic [3:0]             w_offset;
    logic [1:0]             w_idx;
    logic                   w_ctrl_wr;
    logic                   w_clr_req;
    logic                   w_frz_req;
    logic                   w_run;
    logic                   w_rd_oe;
    logic                   w_lo_rd;
    logic [15:0]            w_hi_half;
    logic [DATA_WIDTH-1:0]  w_rdata;
    logic [3:0]             w_cnt_en;
    logic [3:0]             w_sat;
    logic [3:0][c_cnt_width-1:0] w_cnt;
    logic                   w_unused;

    assign w_hit     = (bus_addr[ADDR_WIDTH-1:4] == START_ADDRESS[ADDR_WIDTH-1:4]);
    assign w_offset  = bus_addr[3:0];
    assign w_idx     = cnt_index(w_offset);
    assign w_ctrl_wr = w_hit & write & (w_offset == c_off_ctrl);
    assign w_clr_req = w_ctrl_wr & bus_data[c_ctrl_clear_bit];
    assign w_frz_req = w_ctrl_wr & bus_data[c_ctrl_freeze_bit];
    assign w_run     = (r_state == ST_RUN);
    assign w_lo_rd   = w_hit & read &
                       ((w_offset == c_off_cyc_lo) || (w_offset == c_off_rd_lo) ||
                        (w_offset == c_off_wr_lo)  || (w_offset == c_off_ins_lo));
    assign w_unused  = &{1'b0, bus_data};

    // Accesses to the monitor's own window are counted like any other.
    assign w_cnt_en[c_idx_cyc] = w_run;
    assign w_cnt_en[c_idx_rd]  = w_run & read;
    assign w_cnt_en[c_idx_wr]  = w_run & write;
    assign w_cnt_en[c_idx_ins] = w_run & (pc != r_prev_pc);

    sat_counter #(.WIDTH(c_cnt_width)) u_cyc (
        .clk   (clk),
        .reset (reset),
        .en    (w_cnt_en[c_idx_cyc]),
        .clr   (w_clr_req),
        .count (w_cnt[c_idx_cyc]),
        .sat   (w_sat[c_idx_cyc])
    );

    sat_counter #(.WIDTH(c_cnt_width)) u_rd (
        .clk   (clk),
        .reset (reset),
        .en    (w_cnt_en[c_idx_rd]),
        .clr   (w_clr_req),
        .count (w_cnt[c_idx_rd]),
        .sat   (w_sat[c_idx_rd])
    );

    sat_counter #(.WIDTH(c_cnt_width)) u_wr (
        .clk   (clk),
        .reset (reset),
        .en    (w_cnt_en[c_idx_wr]),
        .clr   (w_clr_req),
        .count (w_cnt[c_idx_wr]),
        .sat   (w_sat[c_idx_wr])
    );

    sat_counter #(.WIDTH(c_cnt_width)) u_ins (
        .clk   (clk),
        .reset (reset),
        .en    (w_cnt_en[c_idx_ins]),
        .clr   (w_clr_req),
        .count (w_cnt[c_idx_ins]),
        .sat   (w_sat[c_idx_ins])
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev_pc <= 10'h3FF;
            r_ovf     <= 1'b0;
        end else begin
            r_prev_pc <= pc;
            if (w_clr_req) begin
                r_ovf <= 1'b0;
            end else if (|w_sat) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Freeze wins over clear when both CTRL bits are written together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_RUN;
            r_frozen <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (halted || w_frz_req) begin
                        r_state  <= ST_FROZEN;
                        r_frozen <= 1'b1;
                    end
                end
                ST_FROZEN: begin
                    if (w_clr_req && !w_frz_req && !halted) begin
                        r_state  <= ST_RUN;
                        r_frozen <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_frozen <= 1'b0;
                end
            endcase
        end
    end

`ifdef PERF_MON_SNAPSHOT_EN
    logic [15:0] r_shadow [4];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_lo_rd) begin
            r_shadow[w_idx] <= w_cnt[w_idx][31:16];
        end
    end

    assign w_hi_half = r_shadow[w_idx];
`else
    assign w_hi_half = w_cnt[w_idx][31:16];
`endif

    always_comb begin
        w_rdata = '0;
        case (w_offset)
            c_off_status: begin
                w_rdata[c_status_frozen_bit] = r_frozen;
                w_rdata[c_status_ovf_bit]    = r_ovf;
            end
            c_off_cyc_lo, c_off_rd_lo, c_off_wr_lo, c_off_ins_lo: begin
                w_rdata[15:0] = w_cnt[w_idx][15:0];
            end
            c_off_cyc_hi, c_off_rd_hi, c_off_wr_hi, c_off_ins_hi: begin
                w_rdata[15:0] = w_hi_half;
            end
            default: begin
                w_rdata = '0;
            end
        endcase
    end

    assign w_rd_oe  = reset & w_hit & read;
    assign bus_data = w_rd_oe ? w_rdata : {DATA_WIDTH{1'bz}};
    assign frozen   = r_frozen & reset;

endmodule
`default_nettype wire

// File: tb/tb_bus_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_perf_monitor
// Brief    : Directed self-checking bench for bus_perf_monitor.
// Revision : 1.0
// ============================================================================
module tb_bus_perf_monitor;

    localparam logic [19:0] c_base = 20'h00400;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] bus_addr;
    wire  [15:0] bus_data;
    logic        read;
    logic        write;
    logic [9:0]  pc;
    logic        halted;
    logic        frozen;
    logic        tb_drv_en;
    logic [15:0] tb_drv_val;

    int n_checks = 0;
    int n_fail   = 0;

    assign bus_data = tb_drv_en ? tb_drv_val : 16'hzzzz;

    always #5 clk = ~clk;

    bus_perf_monitor dut (
        .clk      (clk),
        .reset    (reset),
        .bus_addr (bus_addr),
        .bus_data (bus_data),
        .read     (read),
        .write    (write),
        .pc       (pc),
        .halted   (halted),
        .frozen   (frozen)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        read      = 1'b0;
        write     = 1'b0;
        bus_addr  = 20'h00000;
        tb_drv_en = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] off, input string tag, input logic [15:0] exp);
        bus_addr = c_base + 20'(off);
        read     = 1'b1;
        #1;
        check(tag, {16'h0, bus_data}, {16'h0, exp});
        step();
        bus_idle();
    endtask

    task automatic bus_write(input logic [19:0] addr, input logic [15:0] val);
        bus_addr   = addr;
        write      = 1'b1;
        tb_drv_en  = 1'b1;
        tb_drv_val = val;
        step();
        bus_idle();
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        halted = 1'b0;
        bus_idle();
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        reset      = 1'b0;
        pc         = 10'd0;
        halted     = 1'b0;
        tb_drv_val = 16'h0000;
        bus_idle();

        // Reset state: no drive even on a hit read, not frozen.
        bus_addr = c_base + 20'd1;
        read     = 1'b1;
        #1;
        check("rst_oe", {31'b0, dut.w_rd_oe}, 32'd0);
        check("rst_frozen", {31'b0, frozen}, 32'd0);
        step();
        step();
        bus_idle();
        reset = 1'b1;

        // pc 0,1,2,2,3 -> CYC=5, INS=4
        pc = 10'd0; step();
        pc = 10'd1; step();
        pc = 10'd2; step();
        pc = 10'd2; step();
        pc = 10'd3; step();
        reg_read(4'd2, "cyc_lo_5", 16'd5);
        reg_read(4'd3, "cyc_hi_0", 16'd0);
        reg_read(4'd8, "ins_lo_4", 16'd4);
        reg_read(4'd9, "ins_hi_0", 16'd0);
        reg_read(4'd1, "status_idle", 16'h0000);
        reg_read(4'd4, "rd_own_reads", 16'd5);
        reg_read(4'd12, "unmapped_reads_0", 16'd0);

        // External traffic: 3 reads, 2 writes to 0x00010
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus_addr = 20'h00010; read = 1'b1; step();
            bus_idle(); step();
        end
        for (int i = 0; i < 2; i++) begin
            bus_write(20'h00010, 16'h1234);
            step();
        end
        reg_read(4'd4, "rd_ext_3", 16'd3);
        reg_read(4'd6, "wr_ext_2", 16'd2);
        reg_read(4'd4, "rd_self_5", 16'd5);
        reg_read(4'd5, "rd_hi_0", 16'd0);
        bus_write(c_base + 20'd5, 16'hFFFF);
        reg_read(4'd6, "wr_ignored_off5", 16'd3);
        check("frozen_after_off5_write", {31'b0, frozen}, 32'd0);

        // Halt at cycle 100
        do_reset();
        repeat (99) step();
        halted = 1'b1;
        step();
        check("frozen_at_101", {31'b0, frozen}, 32'd1);
        step(); step(); step();
        reg_read(4'd2, "cyc_frozen_100", 16'd100);
        reg_read(4'd1, "status_frozen", 16'h0001);
        bus_write(c_base, 16'h0001);
        check("clear_while_halted_stays_frozen", {31'b0, frozen}, 32'd1);
        reg_read(4'd2, "cyc_cleared_halted", 16'd0);
        halted = 1'b0;
        step();
        check("no_auto_resume", {31'b0, frozen}, 32'd1);
        bus_write(c_base, 16'h0001);
        check("resume_frozen_0", {31'b0, frozen}, 32'd0);
        reg_read(4'd2, "cyc_after_clear", 16'd0);
        reg_read(4'd4, "rd_after_clear", 16'd1);

        // Software freeze, then freeze+clear together
        bus_write(c_base, 16'h0002);
        check("sw_freeze", {31'b0, frozen}, 32'd1);
        bus_write(c_base, 16'h0003);
        check("freeze_clear_frozen", {31'b0, frozen}, 32'd1);
        reg_read(4'd2, "freeze_clear_cyc", 16'd0);
        reg_read(4'd4, "freeze_clear_rd", 16'd0);
        bus_write(c_base, 16'h0001);
        check("sw_resume", {31'b0, frozen}, 32'd0);

        // Saturation and sticky overflow
        do_reset();
        step(); step();
        force dut.u_cyc.r_count = 32'hFFFF_FFFE;
        step();
        release dut.u_cyc.r_count;
        step(); step();
        reg_read(4'd2, "cyc_sat_lo", 16'hFFFF);
        reg_read(4'd3, "cyc_sat_hi", 16'hFFFF);
        reg_read(4'd1, "status_ovf", 16'h0002);
        bus_write(c_base, 16'h0001);
        reg_read(4'd1, "status_ovf_cleared", 16'h0000);

        // lo read at 0x0000FFFF, hi read on the next cycle
        do_reset();
        step();
        force dut.u_cyc.r_count = 32'h0000_FFFF;
        reg_read(4'd2, "edge_lo_ffff", 16'hFFFF);
        release dut.u_cyc.r_count;
`ifdef PERF_MON_SNAPSHOT_EN
        reg_read(4'd3, "snapshot_hi", 16'h0000);
`endif

        // Mid-run reset
        do_reset();
        repeat (50) step();
        reg_read(4'd2, "cyc_50", 16'd50);
        bus_addr = 20'h00000;
        read     = 1'b1;
        #1;
        check("nohit_oe", {31'b0, dut.w_rd_oe}, 32'd0);
        step();
        bus_idle();
        halted = 1'b1;
        step();
        check("frozen_before_reset", {31'b0, frozen}, 32'd1);
        reset    = 1'b0;
        halted   = 1'b0;
        bus_addr = c_base + 20'd2;
        read     = 1'b1;
        #1;
        check("frozen_in_reset", {31'b0, frozen}, 32'd0);
        check("oe_in_reset", {31'b0, dut.w_rd_oe}, 32'd0);
        step();
        bus_idle();
        reset = 1'b1;
        step();
        reg_read(4'd2, "cyc_after_midreset", 16'd1);
        reg_read(4'd1, "status_after_midreset", 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
